// File: rtl/out_gate_pkg.sv
// Shared types and default constants for the code-locked output gate.
package out_gate_pkg;

    typedef enum logic [2:0] {
        ST_LOCKED  = 3'd0,
        ST_S1      = 3'd1,
        ST_S2      = 3'd2,
        ST_OPEN    = 3'd3,
        ST_LOCKOUT = 3'd4
    } gate_state_e;

    localparam logic [2:0] CODE0_DEF       = 3'd5;
    localparam logic [2:0] CODE1_DEF       = 3'd2;
    localparam logic [2:0] CODE2_DEF       = 3'd7;
    localparam int         OPEN_CYCLES_DEF = 8;
    localparam int         LOCK_CYCLES_DEF = 16;
    localparam int         MAX_FAILS_DEF   = 3;

    // Saturating increment so the failure counter can never pass its limit.
    function automatic logic [1:0] sat_inc(input logic [1:0] v, input logic [1:0] lim);
        return (v >= lim) ? lim : v + 2'd1;
    endfunction

endpackage

// File: rtl/gate_timer.sv
// 8-bit loadable down-counter; zero is a decode of the count register.
module gate_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       en,
    output logic       zero
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != 8'd0)) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == 8'd0);

endmodule

// File: rtl/out_gate_ctrl.sv
// Three-code sequential lock gating a 3-bit payload, with timed open window
// and a lockout after repeated wrong codes.
module out_gate_ctrl
    import out_gate_pkg::*;
#(
    parameter logic [2:0] CODE0       = CODE0_DEF,
    parameter logic [2:0] CODE1       = CODE1_DEF,
    parameter logic [2:0] CODE2       = CODE2_DEF,
    parameter int         OPEN_CYCLES = OPEN_CYCLES_DEF,
    parameter int         LOCK_CYCLES = LOCK_CYCLES_DEF,
    parameter int         MAX_FAILS   = MAX_FAILS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       code_valid,
    input  logic [2:0] user_input,
    input  logic       relock,
    output logic [2:0] out,
    output logic       unlocked,
    output logic       locked_out,
    output logic [1:0] fail_cnt
);

    localparam logic [1:0] MAX_F     = 2'(MAX_FAILS);
    localparam logic [7:0] OPEN_LOAD = 8'(OPEN_CYCLES - 1);
    localparam logic [7:0] LOCK_LOAD = 8'(LOCK_CYCLES - 1);

    gate_state_e state_q, state_d;
    logic [1:0]  fail_q, fail_d, fail_inc;
    logic [2:0]  out_q, out_d;
    logic [2:0]  code_exp;
    logic        tmr_load, tmr_en, tmr_zero;
    logic [7:0]  tmr_val;

    gate_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        fail_d   = fail_q;
        tmr_load = 1'b0;
        tmr_val  = OPEN_LOAD;
        tmr_en   = 1'b0;
        fail_inc = sat_inc(fail_q, MAX_F);

        code_exp = CODE0;
        if (state_q == ST_S1) code_exp = CODE1;
        if (state_q == ST_S2) code_exp = CODE2;

        case (state_q)
            ST_LOCKED, ST_S1, ST_S2: begin
                // relock only matters once part of the sequence has been entered
                if (relock && (state_q != ST_LOCKED)) begin
                    state_d = ST_LOCKED;
                end else if (code_valid) begin
                    if (user_input == code_exp) begin
                        if (state_q == ST_LOCKED) begin
                            state_d = ST_S1;
                        end else if (state_q == ST_S1) begin
                            state_d = ST_S2;
                        end else begin
                            state_d  = ST_OPEN;
                            fail_d   = 2'd0;
                            tmr_load = 1'b1;
                            tmr_val  = OPEN_LOAD;
                        end
                    end else begin
                        fail_d = fail_inc;
                        if (fail_inc == MAX_F) begin
                            state_d  = ST_LOCKOUT;
                            tmr_load = 1'b1;
                            tmr_val  = LOCK_LOAD;
                        end else begin
                            state_d = ST_LOCKED;
                        end
                    end
                end
            end
            ST_OPEN: begin
                if (relock || tmr_zero) begin
                    state_d = ST_LOCKED;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_LOCKOUT: begin
                if (tmr_zero) begin
                    state_d = ST_LOCKED;
                    fail_d  = 2'd0;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            default: state_d = ST_LOCKED;
        endcase

        // Payload passes only while the gate will be open, so it drops the edge it closes.
        out_d = (state_d == ST_OPEN) ? user_input : 3'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LOCKED;
            fail_q  <= 2'd0;
            out_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            fail_q  <= fail_d;
            out_q   <= out_d;
        end
    end

    assign out        = out_q;
    assign unlocked   = (state_q == ST_OPEN);
    assign locked_out = (state_q == ST_LOCKOUT);
    assign fail_cnt   = fail_q;

endmodule

// File: doc/out_gate_ctrl.md
OUT_GATE_CTRL -- requirements
Module: out_gate_ctrl

Interface
REQ-001 Parameter CODE0, default 3'd5: first unlock code.
REQ-002 Parameter CODE1, default 3'd2: second unlock code.
REQ-003 Parameter CODE2, default 3'd7: third unlock code.
REQ-004 Parameter OPEN_CYCLES, default 8: number of cycles the gate stays open, range 1..255.
REQ-005 Parameter LOCK_CYCLES, default 16: duration of lockout in cycles, range 1..255.
REQ-006 Parameter MAX_FAILS, default 3: number of wrong codes that triggers lockout, range 1..3.
REQ-007 clk  input  1  single clock; all state updates on its rising edge.
REQ-008 rst  input  1  reset; synchronous, active-high.
REQ-009 code_valid  input  1  user_input carries a code attempt this cycle.
REQ-010 user_input  input  3  code attempt when code_valid=1; payload data while the gate is open.
REQ-011 relock  input  1  forces return to LOCKED.
REQ-012 out  output  3  gated payload, registered.
REQ-013 unlocked  output  1  high while the FSM is in OPEN.
REQ-014 locked_out  output  1  high while the FSM is in LOCKOUT.
REQ-015 fail_cnt  output  2  current count of wrong attempts.

Function
REQ-016 The FSM SHALL have exactly these states: LOCKED, S1, S2, OPEN and LOCKOUT, in a 3-bit encoding; any unused encoding SHALL go to LOCKED on the next cycle with out=0.
REQ-017 In LOCKED, code_valid with user_input==CODE0 SHALL move the FSM to S1.
REQ-018 In S1, code_valid with user_input==CODE1 SHALL move the FSM to S2.
REQ-019 In S2, code_valid with user_input==CODE2 SHALL move the FSM to OPEN, clear fail_cnt and load the timer with OPEN_CYCLES-1.
REQ-020 In LOCKED, S1 or S2, code_valid with a mismatching code SHALL increment fail_cnt and go to LOCKED.
REQ-021 If that increment brings fail_cnt to MAX_FAILS, the FSM SHALL go to LOCKOUT instead and load the timer with LOCK_CYCLES-1.
REQ-022 In LOCKED, S1 and S2, a cycle without code_valid SHALL hold the state.
REQ-023 In OPEN, the timer SHALL decrement each cycle; when it reaches 0 the FSM SHALL go to LOCKED, so OPEN lasts exactly OPEN_CYCLES cycles.
REQ-024 In LOCKOUT, code_valid SHALL be ignored; when the timer reaches 0 the FSM SHALL go to LOCKED and clear fail_cnt, so LOCKOUT lasts exactly LOCK_CYCLES cycles.
REQ-025 In OPEN, code_valid SHALL be ignored and SHALL NOT change fail_cnt.
REQ-026 relock SHALL have priority over all other inputs: from S1, S2 or OPEN it SHALL go to LOCKED without changing fail_cnt.
REQ-027 relock SHALL have no effect in LOCKOUT or LOCKED.
REQ-028 out SHALL be registered as user_input when the next state is OPEN, and as 3'd0 otherwise.
REQ-029 As a result of REQ-028, out SHALL never be non-zero in the cycle the FSM leaves OPEN.
REQ-030 unlocked and locked_out SHALL be decodes of the state register, and SHALL never be high together.
REQ-031 fail_cnt SHALL saturate and never exceed MAX_FAILS.

Reset
REQ-032 While rst=1, the FSM SHALL be LOCKED, and out=0, unlocked=0, locked_out=0, fail_cnt=0 and timer=0 from the next edge.
REQ-033 rst SHALL override every other input, including mid-OPEN and mid-LOCKOUT.

Structure
REQ-034 Package out_gate_pkg SHALL hold the state enum and the default CODE, CYCLES and MAX_FAILS constants.
REQ-035 The 8-bit loadable down-counter SHALL be a sub-module named gate_timer, with ports load, load_val, en and zero.

Verification
REQ-036 Codes 5,2,7 with code_valid -> unlocked high for exactly 8 cycles; out follows user_input with 1-cycle latency; out=0 in the cycle after.
REQ-037 Codes 5,3 -> fail_cnt=1 and state LOCKED; then 5,2,7 -> OPEN and fail_cnt=0.
REQ-038 Three wrong codes -> locked_out high for 16 cycles; codes 5,2,7 sent during lockout have no effect; afterwards fail_cnt=0.
REQ-039 relock asserted in the 3rd OPEN cycle -> unlocked=0 and out=0 on the next edge; fail_cnt unchanged.
REQ-040 rst pulsed mid-OPEN and mid-LOCKOUT -> all outputs 0 and state LOCKED on the next edge.
REQ-041 State register forced to an unused encoding -> LOCKED on the next cycle, with out=0 throughout.
